// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate strobe, beam counters and sync/blanking decode for a
// raster display.
//
// Ports
//   reloj_nexys  in   system clock, rising edge
//   reset_total  in   synchronous active-high reset
//   enable       in   run (1) / freeze (0)
//   pixel_tick   out  one-cycle strobe every CLK_DIV enabled cycles
//   pixel_x      out  horizontal counter, 0..H_TOTAL-1
//   pixel_y      out  vertical counter, 0..V_TOTAL-1
//   hsync/vsync  out  sync pulses, active level HS_POL/VS_POL
//   video_on     out  beam inside the visible area
//   line_end     out  strobe in the cycle before pixel_x wraps
//   frame_end    out  strobe in the cycle before pixel_x and pixel_y both wrap
//   frame_count  out  completed frames, modulo 2^FRAME_W
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic               reloj_nexys,
    input  logic               reset_total,
    input  logic               enable,
    output logic               pixel_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_end,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Refuse to build a generator whose counters cannot reach the last position.
    if (((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : g_coord_chk
        $error("COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
        $error("CLK_DIV must lie in 1..16");
    end

    logic [3:0]         div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               vid_q, vid_d;
    logic               tick;
    logic               at_line_end;
    logic               at_frame_end;

    always_comb begin
        // Reset suppresses the strobes in the same cycle so nothing leaks out of a reset.
        tick         = enable && !reset_total && (div_q == DIV_LAST);
        at_line_end  = tick && (x_q == H_LAST);
        at_frame_end = at_line_end && (y_q == V_LAST);

        div_d = div_q;
        if (enable) begin
            div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end

        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        fc_d = at_frame_end ? fc_q + 1'b1 : fc_q;

        // Decoding the next counter values keeps the registered syncs aligned with x/y.
        hs_d  = (x_d >= HS_FIRST && x_d <= HS_LAST) ? HS_POL : ~HS_POL;
        vs_d  = (y_d >= VS_FIRST && y_d <= VS_LAST) ? VS_POL : ~VS_POL;
        vid_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge reloj_nexys) begin
        if (reset_total) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            vid_q <= 1'b1;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vid_q <= vid_d;
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vid_q;
    assign line_end    = at_line_end;
    assign frame_end   = at_frame_end;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-sized instance (A) and a tiny fast-wrapping
// instance (B), both driven with random enable/reset and compared every cycle against
// an arithmetic model: the number of enabled cycles since reset fixes everything.
module tb_vga_timing_gen;

    typedef struct {
        int cd;
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int hp, vp;
        int fw;
    } cfg_t;

    localparam cfg_t CFG_A = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
    localparam cfg_t CFG_B = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 2};

    logic clk;
    logic rst_a, en_a, rst_b, en_b;

    logic        a_tick, a_hs, a_vs, a_vid, a_le, a_fe;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_fc;
    logic        b_tick, b_hs, b_vs, b_vid, b_le, b_fe;
    logic [10:0] b_x, b_y;
    logic [1:0]  b_fc;

    int n_chk = 0;
    int n_err = 0;

    vga_timing_gen u_dut_a (
        .reloj_nexys (clk),
        .reset_total (rst_a),
        .enable      (en_a),
        .pixel_tick  (a_tick),
        .pixel_x     (a_x),
        .pixel_y     (a_y),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .video_on    (a_vid),
        .line_end    (a_le),
        .frame_end   (a_fe),
        .frame_count (a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (1), .HS_POL (1'b1), .VS_POL (1'b1), .FRAME_W (2)
    ) u_dut_b (
        .reloj_nexys (clk),
        .reset_total (rst_b),
        .enable      (en_b),
        .pixel_tick  (b_tick),
        .pixel_x     (b_x),
        .pixel_y     (b_y),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .video_on    (b_vid),
        .line_end    (b_le),
        .frame_end   (b_fe),
        .frame_count (b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // n = enabled, non-reset cycles since the last reset edge; en/rst = inputs now applied.
    task automatic check_dut(input string pfx, input cfg_t c, input longint n,
                             input bit en, input bit rst,
                             input logic tick, input logic [10:0] x, input logic [10:0] y,
                             input logic hs, input logic vs, input logic vid,
                             input logic le, input logic fe, input logic [7:0] fc);
        longint ht, vt, p, ex, ey, ef;
        bit     et, ele, efe, ehs, evs, evid;
        ht   = c.ha + c.hfp + c.hs + c.hbp;
        vt   = c.va + c.vfp + c.vs + c.vbp;
        p    = n / c.cd;
        ex   = p % ht;
        ey   = (p / ht) % vt;
        ef   = (p / (ht * vt)) % (64'sd1 << c.fw);
        et   = en && !rst && ((n % c.cd) == c.cd - 1);
        ele  = et && (ex == ht - 1);
        efe  = ele && (ey == vt - 1);
        ehs  = (ex >= c.ha + c.hfp && ex <= c.ha + c.hfp + c.hs - 1) ? c.hp[0] : !c.hp[0];
        evs  = (ey >= c.va + c.vfp && ey <= c.va + c.vfp + c.vs - 1) ? c.vp[0] : !c.vp[0];
        evid = (ex < c.va * 0 + c.ha) && (ey < c.va);
        check_eq({pfx, ".pixel_tick"}, 64'(tick), 64'(et));
        check_eq({pfx, ".pixel_x"},    64'(x),    64'(ex));
        check_eq({pfx, ".pixel_y"},    64'(y),    64'(ey));
        check_eq({pfx, ".hsync"},      64'(hs),   64'(ehs));
        check_eq({pfx, ".vsync"},      64'(vs),   64'(evs));
        check_eq({pfx, ".video_on"},   64'(vid),  64'(evid));
        check_eq({pfx, ".line_end"},   64'(le),   64'(ele));
        check_eq({pfx, ".frame_end"},  64'(fe),   64'(efe));
        check_eq({pfx, ".frame_count"}, 64'(fc),  64'(ef));
    endtask

    initial begin
        longint n_a = 0;
        longint n_b = 0;
        int     hold_a = 0;
        bit     froze_a = 1'b0;
        int     fe_rst_hits = 0;

        rst_a = 1'b1;
        en_a  = 1'b1;
        rst_b = 1'b1;
        en_b  = 1'b1;

        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(posedge clk);
            if (rst_a) n_a = 0;
            else if (en_a) n_a++;
            if (rst_b) n_b = 0;
            else if (en_b) n_b++;
            #1;
            check_dut("A", CFG_A, n_a, en_a, rst_a, a_tick, a_x, a_y, a_hs, a_vs, a_vid,
                      a_le, a_fe, a_fc);
            check_dut("B", CFG_B, n_b, en_b, rst_b, b_tick, b_x, b_y, b_hs, b_vs, b_vid,
                      b_le, b_fe, {6'b0, b_fc});

            // Instance A: mostly running, one mid-line reset, one 10-cycle freeze at x=655.
            rst_a = (cyc < 2) || (cyc == 7000);
            if (!froze_a && !rst_a && (n_a / 4) % 800 == 655 && n_a % 4 == 0) begin
                froze_a = 1'b1;
                hold_a  = 10;
            end
            if (hold_a > 0) begin
                en_a = 1'b0;
                hold_a--;
            end else begin
                en_a = ($urandom_range(0, 49) != 0);
            end

            // Instance B: random enable and resets, plus resets landing on a frame_end.
            rst_b = (cyc < 2) || ($urandom_range(0, 399) == 0);
            en_b  = ($urandom_range(0, 7) != 0);
            if (fe_rst_hits < 3 && n_b >= 48 && n_b % 48 == 47) begin
                rst_b = 1'b1;
                en_b  = 1'b1;
                fe_rst_hits++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width and back porch in lines.
REQ-005 Parameter CLK_DIV, 4, system clocks per pixel, allowed range 1..16.
REQ-006 Parameter HS_POL / VS_POL, 0 / 0, active level of hsync / vsync.
REQ-007 Parameter COORD_W, 11, width of pixel_x and pixel_y; it SHALL hold H_TOTAL-1 and V_TOTAL-1, and elaboration SHALL fail otherwise.
REQ-008 Parameter FRAME_W, 8, width of frame_count.
REQ-009 Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-010 Port reloj_nexys, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-011 Port reset_total, input, 1 bit, synchronous active-high reset.
REQ-012 Port enable, input, 1 bit, run/freeze control.
REQ-013 Port pixel_tick, output, 1 bit, pixel-rate strobe.
REQ-014 Port pixel_x / pixel_y, outputs, COORD_W bits each, current horizontal / vertical counter.
REQ-015 Port hsync / vsync, outputs, 1 bit each, sync signals.
REQ-016 Port video_on, output, 1 bit, high while the beam is in the active area.
REQ-017 Port line_end / frame_end, outputs, 1 bit each, wrap strobes.
REQ-018 Port frame_count, output, FRAME_W bits, count of completed frames.

Function
REQ-019 Divider: counts 0..CLK_DIV-1, advances only while enable=1, and holds its value while enable=0.
REQ-020 pixel_tick is high for exactly one cycle when divider = CLK_DIV-1 and enable = 1; with CLK_DIV=1 it is high every enabled cycle.
REQ-021 pixel_x increments on each pixel_tick; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
REQ-022 pixel_y wraps from V_TOTAL-1 to 0 on the pixel_tick where pixel_x also wraps.
REQ-023 hsync = HS_POL when H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1, and ~HS_POL otherwise.
REQ-024 vsync = VS_POL when V_ACTIVE+V_FP <= pixel_y <= V_ACTIVE+V_FP+V_SYNC-1, and ~VS_POL otherwise.
REQ-025 video_on = (pixel_x < H_ACTIVE) and (pixel_y < V_ACTIVE).
REQ-026 hsync, vsync and video_on are registered outputs, decoded from the next counter values, so they align with pixel_x/pixel_y with zero skew and no glitches.
REQ-027 line_end = pixel_tick and pixel_x = H_TOTAL-1, i.e. high in the cycle before the wrap.
REQ-028 frame_end = line_end and pixel_y = V_TOTAL-1.
REQ-029 frame_count increments in the cycle after frame_end and wraps modulo 2^FRAME_W.
REQ-030 Freeze: while enable=0, every counter and registered output holds, and pixel_tick, line_end and frame_end are 0.
REQ-031 Reset takes priority over enable and over any tick in the same cycle.

Reset
REQ-032 While reset_total=1 at a clock edge, the following clear to 0: divider, pixel_x, pixel_y and frame_count.
REQ-033 While reset_total=1 at a clock edge: hsync = ~HS_POL, vsync = ~VS_POL, video_on = 1, and pixel_tick / line_end / frame_end = 0.
REQ-034 A reset asserted mid-frame yields the REQ-032/033 state on the next edge, with no residual strobe.
REQ-035 After reset release, the first pixel_tick occurs CLK_DIV cycles later, given enable=1.

Verification
REQ-036 Defaults, enable=1, reset released -> pixel_tick every 4 cycles; hsync low for pixel_x 656..751; line_end period 3200 cycles.
REQ-037 Defaults -> vsync low for pixel_y 490..491; video_on low from pixel_x 640 and from pixel_y 480; frame_end period 1,680,000 cycles; frame_count 0->1.
REQ-038 Reset pulse with pixel_x=300, pixel_y=200 -> next edge: pixel_x=0, pixel_y=0, frame_count=0, hsync=1, vsync=1, video_on=1; first pixel_tick 4 cycles after release.
REQ-039 enable dropped for 10 cycles at pixel_x=655 -> all outputs frozen and no strobes; hsync falls on the 4th enabled cycle after enable returns.
REQ-040 CLK_DIV=1, HS_POL=VS_POL=1, H=4/1/2/1, V=3/1/1/1, FRAME_W=2 -> pixel_tick constant; hsync high at x=5..6; vsync high at y=4; frame_end every 48 cycles; frame_count sequence 0,1,2,3,0.
REQ-041 Reset and a frame_end coinciding in the same cycle -> frame_count=0 and all counters 0 on the next edge.
